// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a big-endian byte stream (header word
// count, then N words) into one-cycle word writes and holds the CPU until the image is in.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        inValid,
  input  logic [7:0]  inByte,
  output logic        inReady,
  output logic        memWEn,
  output logic [31:0] memAdr,
  output logic [31:0] memWord,
  output logic        cpuHold,
  output logic        done,
  output logic        err,
  output logic [31:0] wordCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [1:0]  byte_idx;
  logic [31:0] n_words;
  logic [31:0] word_reg;
  logic [31:0] hdr_shift;
  logic [31:0] data_shift;
  logic        in_phase;
  logic        accept;
  logic        last_byte;
  logic        start_load;

  // Ready depends on state alone, so there is no path from inValid back to inReady.
  assign in_phase   = (state == S_HDR) || (state == S_DATA);
  assign inReady    = in_phase;
  assign accept     = inValid && in_phase;
  assign last_byte  = accept && (byte_idx == 2'd3);
  assign start_load = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  assign hdr_shift  = {n_words[23:0], inByte};
  assign data_shift = {word_reg[23:0], inByte};

  // NOTE: every signal written below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    memWEn    = 1'b0;
    cpuHold   = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (last_byte) begin
          if (hdr_shift == 32'd0)      state_nxt = S_DONE;
          else if (hdr_shift > MAX_N)  state_nxt = S_ERR;
          else                         state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte) state_nxt = S_WR;
      end
      S_WR: begin
        memWEn = 1'b1;
        if ((wordCnt + 32'd1) == n_words) state_nxt = S_DONE;
        else                              state_nxt = S_DATA;
      end
      S_DONE: begin
        cpuHold = 1'b0;
        done    = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the assembly registers are plain flops, not a memory array, so they are all reset;
  // this is what guarantees a half-built word is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= 2'd0;
      n_words  <= 32'd0;
      word_reg <= 32'd0;
      memAdr   <= BASE_ADR;
      memWord  <= 32'd0;
      wordCnt  <= 32'd0;
    end else begin
      if (start_load) begin
        byte_idx <= 2'd0;
        n_words  <= 32'd0;
        memAdr   <= BASE_ADR;
        wordCnt  <= 32'd0;
      end
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        if (state == S_HDR) begin
          n_words <= hdr_shift;
        end else begin
          word_reg <= data_shift;
          // Capture the completed word so memWord is already valid during the WR cycle.
          if (byte_idx == 2'd3) memWord <= data_shift;
        end
      end
      if (state == S_WR) begin
        memAdr  <= memAdr + 32'd4;
        wordCnt <= wordCnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-count reference model checked every cycle,
// a write scoreboard against the source image, and directed plus randomized loads.
module tb_imem_loader;

  localparam int unsigned MAX_WORDS = 256;
  localparam logic [31:0] BASE_ADR  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        inValid = 1'b0;
  logic [7:0]  inByte = 8'h00;
  logic        inReady, memWEn, cpuHold, done, err;
  logic [31:0] memAdr, memWord, wordCnt;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADR(BASE_ADR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inValid(inValid), .inByte(inByte),
    .inReady(inReady), .memWEn(memWEn), .memAdr(memAdr), .memWord(memWord),
    .cpuHold(cpuHold), .done(done), .err(err), .wordCnt(wordCnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wlog[$];
  logic [7:0]  stream[$];
  logic [31:0] img[$];
  int          acc_cyc[$];
  int          start_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks the load by counting accepted bytes, not by mirroring the RTL FSM.
  typedef enum {P_IDLE, P_LOAD, P_DONE, P_ERR} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_taken = 0;
  int          m_written = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_n = 32'd0;
  logic [31:0] m_acc = 32'd0;
  logic [31:0] m_last = 32'd0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = P_IDLE; m_taken = 0; m_written = 0; m_wr = 1'b0;
      m_n = 32'd0; m_acc = 32'd0; m_last = 32'd0;
    end else begin
      case (m_phase)
        P_LOAD: begin
          if (m_wr) begin
            m_wr = 1'b0;
            m_written++;
            if (32'(m_written) == m_n) m_phase = P_DONE;
          end else if (inValid) begin
            m_acc = {m_acc[23:0], inByte};
            m_taken++;
            if (m_taken == 4) begin
              m_n = m_acc;
              if (m_n == 32'd0)          m_phase = P_DONE;
              else if (m_n > MAX_WORDS)  m_phase = P_ERR;
            end else if (m_taken % 4 == 0) begin
              m_last = m_acc;
              m_wr   = 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            m_phase = P_LOAD; m_taken = 0; m_written = 0;
          end
        end
      endcase
    end
  end

  // Compare process: all outputs against the model every cycle, plus a write log.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("inReady", 32'(inReady), 32'(m_phase == P_LOAD && !m_wr));
      check("memWEn",  32'(memWEn),  32'(m_wr));
      check("cpuHold", 32'(cpuHold), 32'(m_phase != P_DONE));
      check("done",    32'(done),    32'(m_phase == P_DONE));
      check("err",     32'(err),     32'(m_phase == P_ERR));
      check("wordCnt", wordCnt, 32'(m_written));
      check("memAdr",  memAdr, BASE_ADR + 32'(4 * m_written));
      check("memWord", memWord, m_last);
      if (memWEn) wlog.push_back('{adr: memAdr, data: memWord, cyc: cyc});
    end
  end

  task automatic build(input logic [31:0] hdr);
    stream.delete();
    for (int b = 3; b >= 0; b--) stream.push_back(hdr[8*b +: 8]);
    foreach (img[j]) for (int b = 3; b >= 0; b--) stream.push_back(img[j][8*b +: 8]);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int j = 0; j < n; j++) img.push_back($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    start_cyc = cyc;
  endtask

  // Source side: holds each byte until it is taken; optional forced gap before byte gap_idx.
  task automatic send(input int gap_pct, input int gap_idx, input int gap_len);
    int i = 0;
    int stall = 0;
    int budget = 20 * stream.size() + 100 + gap_len;
    acc_cyc.delete();
    while (i < stream.size()) begin
      @(negedge clk);
      if (budget == 0) begin
        check("send_budget", i, stream.size());
        break;
      end
      budget--;
      if (i == gap_idx && stall < gap_len) begin
        inValid = 1'b0;
        stall++;
      end else begin
        inValid = ($urandom_range(99) >= gap_pct);
        inByte  = stream[i];
        if (inValid && inReady) begin
          acc_cyc.push_back(cyc + 1);
          i++;
        end
      end
    end
    @(negedge clk);
    inValid = 1'b0;
    inByte  = 8'($urandom);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nwr"}, wlog.size(), img.size());
    for (int j = 0; j < img.size() && j < wlog.size(); j++) begin
      check({tag, "_adr"},  wlog[j].adr,  BASE_ADR + 32'(4 * j));
      check({tag, "_data"}, wlog[j].data, img[j]);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_rel0, t1_rel1;
    logic [31:0] hdr;
    int n, gap;

    // Reset state
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_hold", 32'(cpuHold), 32'd1);
    check("rst_adr", memAdr, 32'h0);
    check("rst_cnt", wordCnt, 32'd0);
    check("rst_rdy", 32'(inReady), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: two-word image, inValid held high
    img = '{32'h2408_0005, 32'hAC08_0004};
    build(32'd2);
    wlog.delete();
    pulse_start();
    send(0, -1, 0);
    repeat (2) @(negedge clk);
    check_log("t1");
    check("t1_nwr_lit", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t1_w0_adr", wlog[0].adr, 32'h0000_0000);
      check("t1_w0_dat", wlog[0].data, 32'h2408_0005);
      check("t1_w1_adr", wlog[1].adr, 32'h0000_0004);
      check("t1_w1_dat", wlog[1].data, 32'hAC08_0004);
      check("t1_lat0", wlog[0].cyc, acc_cyc[7]);
      check("t1_lat1", wlog[1].cyc, acc_cyc[11]);
    end
    t1_rel0 = (wlog.size() > 0) ? wlog[0].cyc - start_cyc : -1;
    t1_rel1 = (wlog.size() > 1) ? wlog[1].cyc - start_cyc : -1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpuHold), 32'd0);
    check("t1_cnt", wordCnt, 32'd2);

    // Test 2: same image, 3-cycle gap between bytes 2 and 3 of word 0
    wlog.delete();
    pulse_start();
    send(0, 6, 3);
    repeat (2) @(negedge clk);
    check_log("t2");
    if (wlog.size() == 2) begin
      check("t2_delay0", wlog[0].cyc - start_cyc, t1_rel0 + 3);
      check("t2_delay1", wlog[1].cyc - start_cyc, t1_rel1 + 3);
    end

    // Test 3: empty image, then extra bytes in DONE must not be taken
    img.delete();
    build(32'd0);
    wlog.delete();
    pulse_start();
    send(0, -1, 0);
    check("t3_done", 32'(done), 32'd1);
    check("t3_hold", 32'(cpuHold), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); inValid = 1'b1; inByte = 8'($urandom);
    end
    @(negedge clk); inValid = 1'b0;
    check("t3_nwr", wlog.size(), 0);

    // Test 4: oversize header -> ERR, then recovery with a 1-word image
    img.delete();
    build(32'h0000_0101);
    wlog.delete();
    pulse_start();
    send(0, -1, 0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_hold", 32'(cpuHold), 32'd1);
    check("t4_rdy", 32'(inReady), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_nwr", wlog.size(), 0);
    rand_img(1);
    build(32'd1);
    pulse_start();
    send(0, -1, 0);
    repeat (2) @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_err_clr", 32'(err), 32'd0);
    check_log("t4");

    // Test 5: reset after two bytes of word 1, then a fresh load from address 0
    rand_img(2);
    build(32'd2);
    while (stream.size() > 10) void'(stream.pop_back());
    wlog.delete();
    pulse_start();
    send(0, -1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_hold", 32'(cpuHold), 32'd1);
    check("t5_adr", memAdr, 32'h0);
    check("t5_cnt", wordCnt, 32'd0);
    check("t5_rdy", 32'(inReady), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_partial_nwr", wlog.size(), 1);
    rand_img(2);
    build(32'd2);
    wlog.delete();
    pulse_start();
    send(30, -1, 0);
    repeat (2) @(negedge clk);
    check_log("t5");

    // Test 6: start during DATA ignored; start in DONE reloads
    rand_img(3);
    build(32'd3);
    wlog.delete();
    pulse_start();
    fork
      send(0, -1, 0);
      begin
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check_log("t6");
    check("t6_done", 32'(done), 32'd1);
    pulse_start();
    check("t6_reload_hold", 32'(cpuHold), 32'd1);
    check("t6_reload_done", 32'(done), 32'd0);
    check("t6_reload_rdy", 32'(inReady), 32'd1);

    // Capacity boundary: exactly MAX_WORDS words
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_img(MAX_WORDS);
    build(32'(MAX_WORDS));
    wlog.delete();
    pulse_start();
    send(0, -1, 0);
    repeat (2) @(negedge clk);
    check_log("max");
    check("max_cnt", wordCnt, 32'd256);
    check("max_adr", memAdr, 32'h0000_0400);
    if (wlog.size() == MAX_WORDS) check("max_last_adr", wlog[MAX_WORDS-1].adr, 32'h0000_03FC);

    // Randomized loads with random gaps, header values and early start pulses
    for (int r = 0; r < 14; r++) begin
      gap = $urandom_range(60);
      case ($urandom_range(9))
        0:       n = -1;
        1:       n = 0;
        default: n = $urandom_range(8, 1);
      endcase
      if (n < 0) begin
        img.delete();
        hdr = ($urandom_range(1)) ? 32'hFFFF_FFFF : 32'(MAX_WORDS + 1 + $urandom_range(1000));
      end else begin
        rand_img(n);
        hdr = 32'(n);
      end
      build(hdr);
      wlog.delete();
      pulse_start();
      fork
        send(gap, -1, 0);
        if ($urandom_range(1)) begin
          repeat ($urandom_range(3, 1)) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      join
      repeat (3) @(negedge clk);
      if (n < 0) begin
        check("rnd_err", 32'(err), 32'd1);
        check("rnd_err_nwr", wlog.size(), 0);
      end else begin
        check("rnd_done", 32'(done), 32'd1);
        check_log("rnd");
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory, which the CPU datapath only ever reads.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one-cycle word writes at word-aligned byte addresses, in the same address space the PC walks (0, 4, 8, ...).
- Holds the CPU stalled via cpuHold until the image is fully written, then releases it.

Parameters:
MAX_WORDS, 256, capacity of instruction memory in 32-bit words; larger images are rejected
BASE_ADR, 0, byte address of the first written word (multiple of 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR
inValid  input  1  source has a byte on inByte
inByte  input  8  stream byte
inReady  output  1  loader accepts inByte this cycle
memWEn  output  1  instruction-memory write enable, one cycle per word
memAdr  output  32  byte address of the write
memWord  output  32  write data
cpuHold  output  1  1 = CPU must not advance its PC
done  output  1  image fully written
err  output  1  header word count exceeded MAX_WORDS
wordCnt  output  32  words written so far in the current load

Behaviour:
- Byte transfer happens only when inValid && inReady on a rising edge. Otherwise the source holds its byte.
- inReady is combinational from state only: 1 in HDR and DATA, 0 everywhere else.
- Stream format:
  - first 4 bytes are header N, the word count, MSB first;
  - then N words of 4 bytes each, MSB first (byte0 -> [31:24], byte3 -> [7:0]).
- State IDLE: inReady=0, cpuHold=1. start -> HDR; clear byteIdx, wordCnt, done, err; set memAdr=BASE_ADR.
- State HDR: shift accepted bytes into an N register. On the 4th accepted byte:
  - N==0 -> DONE;
  - N>MAX_WORDS -> ERR;
  - otherwise -> DATA.
- State DATA: shift accepted bytes into the word register. On the 4th accepted byte -> WR.
- State WR, exactly one cycle: memWEn=1, memWord=assembled word, memAdr=current address, inReady=0. Next edge:
  - memAdr += 4; wordCnt += 1;
  - if the new wordCnt == N -> DONE, else -> DATA.
- State DONE: done=1, cpuHold=0, inReady=0. Extra stream bytes are not consumed. start -> HDR (reload).
- State ERR: err=1, cpuHold=1, inReady=0. start -> HDR.
- start is ignored in HDR, DATA and WR.
- Address arithmetic:
  - 32-bit unsigned, +4 per word;
  - last written address = BASE_ADR + 4*(N-1);
  - no wrap is possible because N <= MAX_WORDS.
- Throughput: minimum 5 cycles per word (4 accepts + 1 WR). inValid gaps stall without losing assembled bytes.
- Reset (rst_n=0 on an edge), from any state including mid-word or during WR:
  - state=IDLE; byteIdx=0; N=0; word register=0;
  - memAdr=BASE_ADR; memWord=0; memWEn=0; wordCnt=0;
  - done=0; err=0; cpuHold=1.
  - A partially assembled word is discarded and never written.
- memWEn is never asserted outside WR. memWord and memAdr hold their values outside WR.
- Outputs are registered or decoded from registered state only. No combinational path from inValid to memWEn.

Test Plan:
1. Reset, start pulse, stream 00 00 00 02 | 24 08 00 05 | AC 08 00 04 with inValid held 1 -> memWEn pulses twice:
   - adr 0x0 data 0x24080005, adr 0x4 data 0xAC080004;
   - each pulse follows its 4th byte by exactly one cycle;
   - done=1, cpuHold=0, wordCnt=2.
2. Same image with inValid dropped for 3 cycles between bytes 2 and 3 of word 0 -> identical writes, delayed by 3 cycles; no byte lost or duplicated.
3. Header 00 00 00 00 -> no memWEn; DONE one edge after the 4th header byte; cpuHold=0.
4. Header 00 00 01 01 (257 > 256) -> ERR, err=1, cpuHold=1, inReady=0, no writes. A subsequent start plus a valid 1-word image -> done=1, err=0.
5. rst_n=0 for one cycle after 2 bytes of word 1 -> next cycle IDLE, memAdr=0, wordCnt=0, cpuHold=1. A fresh full load rewrites from address 0.
6. start pulsed during DATA -> ignored; load completes normally. start pulsed in DONE -> returns to HDR, cpuHold=1, done=0.
